// File: rtl/ldpc_conv_pkg.sv
// ldpc_conv_pkg: shared definitions for the LLR sign-magnitude / two's
// complement stream converter.
//   conv_mode_e : per-beat conversion direction (S2T = 0, T2S = 1)
//   DEFAULT_W   : default LLR lane width (sign bit + W-1 magnitude bits)
package ldpc_conv_pkg;

  typedef enum logic {
    MODE_S2T = 1'b0,
    MODE_T2S = 1'b1
  } conv_mode_e;

  localparam int DEFAULT_W = 5;

endpackage

// File: rtl/sm_tc_lane.sv
// sm_tc_lane: combinational conversion of one W-bit LLR lane.
// Ports:
//   inp  [W-1:0] in  : lane value (sign-magnitude or two's complement)
//   mode         in  : MODE_S2T or MODE_T2S
//   out  [W-1:0] out : converted lane value
//   sat          out : set when the T2S input has no sign-magnitude equivalent
module sm_tc_lane
  import ldpc_conv_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic [W-1:0] inp,
  input  logic         mode,
  output logic [W-1:0] out,
  output logic         sat
);

  logic         sign;
  logic [W-2:0] mag;
  logic         mag_zero;
  logic [W-1:0] neg_mag;
  logic [W-1:0] neg_x;

  assign sign     = inp[W-1];
  assign mag      = inp[W-2:0];
  assign mag_zero = (mag == '0);
  assign neg_mag  = -{1'b0, mag};
  // For any negative x other than the most negative one, -x fits in W-1 bits.
  assign neg_x    = -inp;

  always_comb begin
    out = inp;
    sat = 1'b0;
    if (mode == MODE_T2S) begin
      if (sign) begin
        if (mag_zero) begin
          // Most negative code has no SM form: clamp to -(2^(W-1)-1).
          out = '1;
          sat = 1'b1;
        end else begin
          out = {1'b1, neg_x[W-2:0]};
        end
      end
    end else begin
      // Negative zero collapses to the single two's complement zero.
      if (sign) out = mag_zero ? '0 : neg_mag;
    end
  end

endmodule

// File: rtl/sm_tc_stream_conv.sv
// sm_tc_stream_conv: valid/ready stream converter between sign-magnitude and
// two's complement LLR lanes, with a 2-entry (output + skid) buffer and a
// saturating count of clamped lanes.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : input handshake (in_ready registered)
//   in_mode               : conversion direction for this beat
//   in_data [LANES*W]     : packed input lanes, lane i at [i*W +: W]
//   out_valid/out_ready   : output handshake
//   out_data [LANES*W]    : packed converted lanes
//   out_sat  [LANES]      : per-lane saturation flags of the output beat
//   sat_clr               : synchronous clear of sat_count (wins over increment)
//   sat_count [CNT_W]     : saturating count of saturated lanes delivered
module sm_tc_stream_conv
  import ldpc_conv_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [LANES*W-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   out_data,
  output logic [LANES-1:0]     out_sat,
  input  logic                 sat_clr,
  output logic [CNT_W-1:0]     sat_count
);

  localparam int DW = LANES * W;
  localparam int PW = $clog2(LANES + 1);

  logic [DW-1:0]    conv_data;
  logic [LANES-1:0] conv_sat;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    sm_tc_lane #(.W(W)) u_lane (
      .inp  (in_data[gi*W +: W]),
      .mode (in_mode),
      .out  (conv_data[gi*W +: W]),
      .sat  (conv_sat[gi])
    );
  end

  logic [DW-1:0]    out_data_q, out_data_d;
  logic [LANES-1:0] out_sat_q, out_sat_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    skid_data_q, skid_data_d;
  logic [LANES-1:0] skid_sat_q, skid_sat_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] sat_count_q, sat_count_d;

  logic             accept;
  logic             complete;
  logic [PW-1:0]    pop_cnt;
  logic [CNT_W:0]   sum;

  assign accept   = in_valid && in_ready_q;
  assign complete = out_valid_q && out_ready;

  always_comb begin
    out_data_d   = out_data_q;
    out_sat_d    = out_sat_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_sat_d   = skid_sat_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || out_ready) begin
      // Output register is free this cycle: the skid entry is older than
      // anything on the input, and in_ready is low whenever it is occupied.
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_sat_d    = skid_sat_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_data_d  = conv_data;
        out_sat_d   = conv_sat;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_data_d  = conv_data;
      skid_sat_d   = conv_sat;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      pop_cnt = pop_cnt + PW'(out_sat_q[i]);
    end
    // One extra bit catches the overflow so the count can clamp at all-ones.
    sum = {1'b0, sat_count_q} + (CNT_W+1)'(pop_cnt);
    sat_count_d = sat_count_q;
    if (sat_clr) begin
      sat_count_d = '0;
    end else if (complete) begin
      sat_count_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      out_sat_q    <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_sat_q   <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      sat_count_q  <= '0;
    end else begin
      out_data_q   <= out_data_d;
      out_sat_q    <= out_sat_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_sat_q   <= skid_sat_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      sat_count_q  <= sat_count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign sat_count = sat_count_q;

endmodule
